// File: rtl/sprite_blitter.sv
// sprite_blitter: walks one SPRITE_W x SPRITE_H sprite from a synchronous ROM
// and streams its pixels to the VGA adapter. Transparent pixels and pixels
// past the right or bottom screen edge are suppressed.
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   start                  draw request, sampled only in IDLE
//   sprite_id/base_x/base_y  sprite select and top-left corner, latched on accept
//   busy, done             busy from accept through the done pulse; done one cycle
//   rom_addr, rom_data     ROM read address (combinational) / data (1-cycle latency)
//   x, y, colour, plot     registered pixel write to the VGA adapter
module sprite_blitter #(
  parameter int unsigned SPRITE_W    = 8,
  parameter int unsigned SPRITE_H    = 8,
  parameter int unsigned NUM_SPRITES = 4,
  parameter int unsigned SCREEN_W    = 160,
  parameter int unsigned SCREEN_H    = 120,
  parameter logic [8:0]  TRANSPARENT = 9'h1FF,
  parameter int unsigned ROM_AW      = 8
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           start,
  input  logic [$clog2(NUM_SPRITES)-1:0] sprite_id,
  input  logic [7:0]                     base_x,
  input  logic [6:0]                     base_y,
  output logic                           busy,
  output logic                           done,
  output logic [ROM_AW-1:0]              rom_addr,
  input  logic [8:0]                     rom_data,
  output logic [7:0]                     x,
  output logic [6:0]                     y,
  output logic [8:0]                     colour,
  output logic                           plot
);

  localparam int unsigned IDW = $clog2(NUM_SPRITES);
  localparam int unsigned CW  = $clog2(SPRITE_W);
  localparam int unsigned RW  = $clog2(SPRITE_H);
  localparam logic [8:0]  SCR_W9 = 9'(SCREEN_W);
  localparam logic [7:0]  SCR_H8 = 8'(SCREEN_H);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // Position tag travelling alongside the ROM read
  typedef struct packed {
    logic       valid;
    logic [8:0] sx;
    logic [7:0] sy;
  } tag_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  col_q, col_d;
  logic [RW-1:0]  row_q, row_d;
  logic           drain_q, drain_d;
  logic [IDW-1:0] id_q, id_d;
  logic [7:0]     bx_q, bx_d;
  logic [6:0]     by_q, by_d;
  tag_t           tag_q;
  logic           busy_q, done_q, plot_q;
  logic [7:0]     x_q;
  logic [6:0]     y_q;
  logic [8:0]     colour_q;
  logic           plot_c;

  // Next-state and counter logic
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    drain_d = drain_q;
    id_d    = id_q;
    bx_d    = bx_q;
    by_d    = by_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          id_d    = sprite_id;
          bx_d    = base_x;
          by_d    = base_y;
          col_d   = '0;
          row_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        col_d = col_q + CW'(1);
        if (col_q == CW'(SPRITE_W - 1)) begin
          col_d = '0;
          row_d = row_q + RW'(1);
          if (row_q == RW'(SPRITE_H - 1)) begin
            row_d   = '0;
            drain_d = 1'b0;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (drain_q) state_d = DONE;
        else         drain_d = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sprites are power-of-two sized, so the linear address is a concatenation
  assign rom_addr = (state_q == RUN) ? ROM_AW'({id_q, row_q, col_q}) : '0;

  assign plot_c = tag_q.valid && (rom_data != TRANSPARENT) &&
                  (tag_q.sx < SCR_W9) && (tag_q.sy < SCR_H8);

  // State, counters, tag pipe and registered pixel outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      col_q    <= '0;
      row_q    <= '0;
      drain_q  <= 1'b0;
      id_q     <= '0;
      bx_q     <= '0;
      by_q     <= '0;
      tag_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      plot_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      drain_q     <= drain_d;
      id_q        <= id_d;
      bx_q        <= bx_d;
      by_q        <= by_d;
      tag_q.valid <= (state_q == RUN);
      tag_q.sx    <= 9'(bx_q) + 9'(col_q);
      tag_q.sy    <= 8'(by_q) + 8'(row_q);
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_d == DONE);
      plot_q      <= plot_c;
      // Pixel fields only move on a real plot; the adapter ignores them otherwise
      if (plot_c) begin
        x_q      <= tag_q.sx[7:0];
        y_q      <= tag_q.sy[6:0];
        colour_q <= rom_data;
      end
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign plot   = plot_q;
  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed testbench for sprite_blitter with a synchronous ROM model.
module tb_sprite_blitter;

  logic       clk;
  logic       resetn;
  logic       start;
  logic [1:0] sprite_id;
  logic [7:0] base_x;
  logic [6:0] base_y;
  logic       busy, done, plot;
  logic [7:0] rom_addr;
  logic [8:0] rom_data;
  logic [7:0] x;
  logic [6:0] y;
  logic [8:0] colour;

  logic [8:0] rom_mem [256];

  int n_checks = 0;
  int n_errors = 0;

  sprite_blitter dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .sprite_id (sprite_id),
    .base_x    (base_x),
    .base_y    (base_y),
    .busy      (busy),
    .done      (done),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .plot      (plot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: data one cycle after address
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One draw from the accepting cycle. restart_at: cycle to pulse a spurious
  // start (also pulsed during the done cycle). reset_at: cycle to abort by reset.
  task automatic run_draw(input logic [1:0] id, input logic [7:0] bx, input logic [6:0] by,
                          input int exp_plots, input int restart_at, input int reset_at);
    int nplots = 0;
    int ndone  = 0;
    @(negedge clk);
    sprite_id = id;
    base_x    = bx;
    base_y    = by;
    start     = 1'b1;
    for (int k = 1; k <= 68; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (restart_at > 0 && k == restart_at + 1) start = 1'b0;
      if (restart_at > 0 && k == 68) start = 1'b0;
      check($sformatf("busy@%0d", k), 32'(busy), 32'(k <= 67));
      check($sformatf("done@%0d", k), 32'(done), 32'(k == 67));
      if (done) ndone++;
      if (k == 1)  check("rom_addr_first", 32'(rom_addr), 32'(id) * 64);
      if (k == 68) check("rom_addr_idle", 32'(rom_addr), 32'd0);
      begin
        logic ep;
        int p, ex, ey;
        logic [8:0] pc;
        ep = 1'b0;
        ex = 0; ey = 0; pc = '0;
        if (k >= 3 && k <= 66) begin
          p  = k - 3;
          pc = rom_mem[int'(id) * 64 + p];
          ex = int'(bx) + p % 8;
          ey = int'(by) + p / 8;
          ep = (pc != 9'h1FF) && (ex < 160) && (ey < 120);
        end
        check($sformatf("plot@%0d", k), 32'(plot), 32'(ep));
        if (ep && plot) begin
          nplots++;
          check($sformatf("x@%0d", k), 32'(x), 32'(ex));
          check($sformatf("y@%0d", k), 32'(y), 32'(ey));
          check($sformatf("colour@%0d", k), 32'(colour), 32'(pc));
        end
      end
      if (reset_at > 0 && k == reset_at) begin
        resetn = 1'b0;
        #1;
        check("abort_plot", 32'(plot), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        for (int j = 0; j < 4; j++) begin
          @(negedge clk);
          if (plot || busy || done) ndone += 100;
        end
        check("abort_quiet", 32'(ndone), 32'd0);
        resetn = 1'b1;
        return;
      end
      if (restart_at > 0 && (k == restart_at || k == 67)) begin
        sprite_id = 2'd2;
        base_x    = 8'd0;
        base_y    = 7'd0;
        start     = 1'b1;
      end
    end
    check("plot_count", 32'(nplots), 32'(exp_plots));
    check("done_count", 32'(ndone), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      if (i < 64)       rom_mem[i] = 9'h049;
      else if (i < 128) rom_mem[i] = (((i % 8) + ((i - 64) / 8)) % 2 == 0) ? 9'h1FF : 9'h1C0;
      else if (i < 192) rom_mem[i] = 9'h0F0;
      else              rom_mem[i] = 9'h123;
    end
    resetn    = 1'b0;
    start     = 1'b0;
    sprite_id = '0;
    base_x    = '0;
    base_y    = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_done",     32'(done),     32'd0);
    check("rst_plot",     32'(plot),     32'd0);
    check("rst_x",        32'(x),        32'd0);
    check("rst_y",        32'(y),        32'd0);
    check("rst_colour",   32'(colour),   32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    run_draw(2'd0, 8'd10,  7'd20,  64, 0, 0);   // opaque sprite
    run_draw(2'd1, 8'd30,  7'd40,  32, 0, 0);   // checkerboard
    run_draw(2'd0, 8'd156, 7'd116, 16, 0, 0);   // right/bottom clip
    run_draw(2'd3, 8'd40,  7'd50,  64, 30, 0);  // ignored starts
    run_draw(2'd2, 8'd5,   7'd6,   64, 0, 0);   // accepted after done
    run_draw(2'd0, 8'd0,   7'd0,   0, 0, 23);   // abort at pixel 20
    run_draw(2'd3, 8'd0,   7'd0,   64, 0, 0);   // recovery
    run_draw(2'd2, 8'd159, 7'd119, 1, 0, 0);    // single corner pixel

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
